instr_decode_stage: RTL

Instruction decode stage that sits directly downstream of instruction fetch. It holds the IF/ID pipeline register and the 32×32 register file, and splits the fetched word into fields and a 32-bit immediate. It detects load-use hazards and drives the `hazard` stall line back to fetch. Branch or jump redirects flush it.

---
 rtl/instr_decode_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: IF/ID pipeline register, register file, field/immediate decode and load-use hazard detection.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle WB write onto the register read ports.
module instr_decode_stage #(
  parameter int unsigned REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        hazard,
  output logic        id_valid,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [31:0] id_imm,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc4_q;
  logic            valid_q;
  logic [XLEN-1:0] regs [REG_COUNT];

  // IF/ID register: reset > flush > stall hold > load
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (!hazard) begin
      instr_q <= if_instr;
      pc4_q   <= if_pc4;
      valid_q <= 1'b1;
    end
  end

  // Register file; entry 0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign id_opcode = instr_q[31:26];
  assign id_rs     = instr_q[25:21];
  assign id_rt     = instr_q[20:16];
  assign id_rd     = instr_q[15:11];
  assign id_funct  = instr_q[5:0];
  assign id_pc4    = pc4_q;

  // Logical immediates zero-extend, lui shifts up, everything else sign-extends
  always_comb begin
    id_imm = {{16{instr_q[15]}}, instr_q[15:0]};
    case (id_opcode)
      OP_ANDI, OP_ORI, OP_XORI: id_imm = {16'd0, instr_q[15:0]};
      OP_LUI:                   id_imm = {instr_q[15:0], 16'd0};
      default:                  ;
    endcase
  end

  assign hazard = valid_q & ex_mem_read & (ex_rt != 5'd0)
                & ((ex_rt == id_rs) | (ex_rt == id_rt));

  assign id_valid = valid_q & ~hazard;

  always_comb begin
    id_rs_data = (id_rs == 5'd0) ? '0 : regs[id_rs];
    id_rt_data = (id_rt == 5'd0) ? '0 : regs[id_rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rs)) id_rs_data = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == id_rt)) id_rt_data = wb_data;
`endif
  end

endmodule
